// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the MM:SS stopwatch display.
// Types for the FSM, the BCD digits and the active-low segment decode table.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUNNING,
    PAUSED
  } state_t;

  typedef logic [3:0] bcd_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] SEG_LUT [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, SEG_BLANK,  SEG_BLANK,
    SEG_BLANK,  SEG_BLANK,  SEG_BLANK,  SEG_BLANK
  };

endpackage

// File: rtl/stopwatch_display_sync.sv
// Input synchroniser plus registered rising-edge detector.
// rise is a 1-cycle pulse, SYNC_STAGES+1 cycles after the din edge.
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic din,
  output logic sync,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sff;
  logic                   prev;

  assign sync = sff[SYNC_STAGES-1];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sff  <= '0;
      prev <= 1'b0;
      rise <= 1'b0;
    end else begin
      sff  <= {sff[SYNC_STAGES-2:0], din};
      prev <= sync;
      rise <= sync & ~prev;
    end
  end

endmodule

// File: rtl/stopwatch_display.sv
// MM:SS stopwatch with 4-digit multiplexed 7-segment driver.
// Define SW_LAP_EN to enable the lap (display freeze) feature.
module stopwatch_display
  import stopwatch_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_MIN     = 59
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       clock1Hz,
  input  logic       clock500Hz,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       lap,
  output logic [3:0] anode,
  output logic [6:0] seg,
  output logic       running,
  output logic       wrap
);

  localparam bcd_t MAX_M10 = bcd_t'(MAX_MIN / 10);
  localparam bcd_t MAX_M1  = bcd_t'(MAX_MIN % 10);

  logic [4:0] din;
  logic [4:0] rise;
  logic [4:0] sync_unused;

  assign din = {lap, clear, start_stop, clock500Hz, clock1Hz};

  for (genvar i = 0; i < 5; i++) begin : g_sync
    sync_edge_detect #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
      .clock  (clock),
      .reset_n(reset_n),
      .din    (din[i]),
      .sync   (sync_unused[i]),
      .rise   (rise[i])
    );
  end

  logic tick, scan, ss_p, clr_p;

  assign tick  = rise[0];
  assign scan  = rise[1];
  assign ss_p  = rise[2];
  assign clr_p = rise[3];

  state_t     state;
  bcd_t [3:0] cnt;
  bcd_t [3:0] nxt;
  bcd_t [3:0] disp;
  logic       at_max;

  // digit order: [0]=s1 [1]=s10 [2]=m1 [3]=m10
  always_comb begin
    nxt    = cnt;
    at_max = 1'b0;
    if (cnt[0] != 4'd9) begin
      nxt[0] = cnt[0] + 4'd1;
    end else begin
      nxt[0] = '0;
      if (cnt[1] != 4'd5) begin
        nxt[1] = cnt[1] + 4'd1;
      end else begin
        nxt[1] = '0;
        if (cnt[3] == MAX_M10 && cnt[2] == MAX_M1) begin
          nxt[3] = '0;
          nxt[2] = '0;
          at_max = 1'b1;
        end else if (cnt[2] != 4'd9) begin
          nxt[2] = cnt[2] + 4'd1;
        end else begin
          nxt[2] = '0;
          nxt[3] = cnt[3] + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      running <= 1'b0;
      wrap    <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (clr_p) begin
        state   <= IDLE;
        cnt     <= '0;
        running <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (ss_p) begin
              state   <= RUNNING;
              running <= 1'b1;
            end
          end
          RUNNING: begin
            if (tick) begin
              cnt  <= nxt;
              wrap <= at_max;
            end
            if (ss_p) begin
              state   <= PAUSED;
              running <= 1'b0;
            end
          end
          PAUSED: begin
            if (ss_p) begin
              state   <= RUNNING;
              running <= 1'b1;
            end
          end
          default: begin
            state   <= IDLE;
            running <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef SW_LAP_EN
  logic       freeze;
  bcd_t [3:0] snap;
  logic       lap_p;

  assign lap_p = rise[4];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      freeze <= 1'b0;
      snap   <= '0;
    end else if (clr_p) begin
      freeze <= 1'b0;
    end else if (lap_p) begin
      if (freeze) begin
        freeze <= 1'b0;
      end else if (state == RUNNING) begin
        snap   <= cnt;
        freeze <= 1'b1;
      end
    end
  end

  assign disp = freeze ? snap : cnt;
`else
  logic lap_unused;

  assign lap_unused = rise[4];
  assign disp       = cnt;
`endif

  logic [1:0] idx;

  // anode and seg both follow idx one cycle later, so they switch together
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      idx   <= '0;
      anode <= 4'b1110;
      seg   <= SEG_LUT[0];
    end else begin
      if (scan) idx <= idx + 2'd1;
      anode <= ~(4'b0001 << idx);
      seg   <= SEG_LUT[disp[idx]];
    end
  end

endmodule

// File: tb/tb_stopwatch_display.sv
// Self-checking bench for stopwatch_display: directed cases plus
// randomized events checked against a seconds-based reference model.
module tb_stopwatch_display;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       c1 = 1'b0;
  logic       c500 = 1'b0;
  logic       ss = 1'b0;
  logic       clr = 1'b0;
  logic       lap = 1'b0;
  logic [3:0] anode;
  logic [6:0] seg;
  logic       running;
  logic       wrap;

  always #5 clock = ~clock;

  stopwatch_display dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .clock1Hz  (c1),
    .clock500Hz(c500),
    .start_stop(ss),
    .clear     (clr),
    .lap       (lap),
    .anode     (anode),
    .seg       (seg),
    .running   (running),
    .wrap      (wrap)
  );

  localparam int MAXS = 59 * 60 + 59;

  int n_chk = 0;
  int n_fail = 0;

  // reference model: total seconds, run flag, lap freeze, scan index
  int secs = 0;
  bit run = 1'b0;
  bit frz = 1'b0;
  int snap = 0;
  int m_idx = 0;
  int last_wrap = 0;

  logic [6:0] lut [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };
  int aseq [4] = '{14, 13, 11, 7};
  int pw [4] = '{1, 10, 100, 1000};

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int seg2dig(input logic [6:0] s);
    for (int i = 0; i < 10; i++) if (lut[i] == s) return i;
    return 99;
  endfunction

  function automatic int mmss(input int x);
    return (x / 60) * 100 + x % 60;
  endfunction

  // one event: rising edges on the selected inputs, 8 cycles total
  task automatic ev(input bit t, input bit s, input bit c,
                    input bit sc, input bit l);
    int wcnt;
    int wexp;
    bit pre_run;
    int pre_secs;
    wcnt = 0;
    wexp = 0;
    c1 = t; ss = s; clr = c; c500 = sc; lap = l;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (i == 4) begin
        c1 = 0; ss = 0; clr = 0; c500 = 0; lap = 0;
      end
      wcnt += int'(wrap);
    end
    pre_run  = run;
    pre_secs = secs;
    if (c) begin
      secs = 0;
      run  = 1'b0;
      frz  = 1'b0;
    end else begin
      if (pre_run && t) begin
        if (secs == MAXS) begin
          secs = 0;
          wexp = 1;
        end else begin
          secs++;
        end
      end
      if (s) run = !run;
`ifdef SW_LAP_EN
      if (l) begin
        if (frz) frz = 1'b0;
        else if (pre_run) begin
          snap = pre_secs;
          frz  = 1'b1;
        end
      end
`endif
    end
    if (sc) m_idx = (m_idx + 1) % 4;
    last_wrap = wcnt;
    chk("wrap", wcnt, wexp);
    chk("running", int'(running), int'(run));
  endtask

  task automatic read_disp(output int val);
    int d [4];
    for (int k = 0; k < 4; k++) begin
      ev(0, 0, 0, 1, 0);
      chk("anode", int'(anode), 15 - (1 << m_idx));
      d[m_idx] = seg2dig(seg);
    end
    val = d[3] * 1000 + d[2] * 100 + d[1] * 10 + d[0];
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) ev(1, 0, 0, 0, 0);
  endtask

  function automatic int shown();
    return mmss(frz ? snap : secs);
  endfunction

  int v;

  initial begin
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    // 1: reset state, ticks ignored in IDLE
    chk("rst_anode", int'(anode), 14);
    chk("rst_seg", int'(seg), 64);
    chk("rst_running", int'(running), 0);
    ticks(10);
    read_disp(v);
    chk("t1_disp", v, 0);

    // 2: run 75 s, then pause
    ev(0, 1, 0, 0, 0);
    ticks(75);
    read_disp(v);
    chk("t2_disp", v, 115);
    chk("t2_run", int'(running), 1);
    ev(0, 1, 0, 0, 0);
    ticks(10);
    read_disp(v);
    chk("t2_pause_disp", v, 115);
    chk("t2_pause_run", int'(running), 0);

    // 3: wrap at 59:59
    ev(0, 0, 1, 0, 0);
    ev(0, 1, 0, 0, 0);
    ticks(3598);
    read_disp(v);
    chk("t3_5958", v, 5958);
    ev(1, 0, 0, 0, 0);
    chk("t3_nowrap", last_wrap, 0);
    read_disp(v);
    chk("t3_5959", v, 5959);
    ev(1, 0, 0, 0, 0);
    chk("t3_wrap", last_wrap, 1);
    read_disp(v);
    chk("t3_0000", v, 0);
    chk("t3_run", int'(running), 1);

    // 4: clear beats start_stop
    ticks(42);
    read_disp(v);
    chk("t4_42", v, 42);
    ev(0, 1, 1, 0, 0);
    chk("t4_run", int'(running), 0);
    read_disp(v);
    chk("t4_disp", v, 0);

    // async reset mid-count
    ev(0, 1, 0, 0, 0);
    ticks(5);
    ev(0, 0, 0, 1, 0);
    @(posedge clock);
    #3 reset_n = 1'b0;
    #1;
    chk("ar_anode", int'(anode), 14);
    chk("ar_seg", int'(seg), 64);
    chk("ar_running", int'(running), 0);
    @(negedge clock);
    reset_n = 1'b1;
    secs = 0; run = 1'b0; frz = 1'b0; m_idx = 0;
    @(negedge clock);
    read_disp(v);
    chk("ar_disp", v, 0);

    // 5: scan walk over 12:34
    ev(0, 1, 0, 0, 0);
    ticks(754);
    ev(0, 1, 0, 0, 0);
    for (int k = 1; k <= 8; k++) begin
      ev(0, 0, 0, 1, 0);
      chk("t5_anode", int'(anode), aseq[k % 4]);
      chk("t5_seg", int'(seg), int'(lut[(1234 / pw[k % 4]) % 10]));
    end

`ifdef SW_LAP_EN
    // 6: lap freeze
    ev(0, 0, 1, 0, 0);
    ev(0, 1, 0, 0, 0);
    ticks(10);
    ev(0, 0, 0, 0, 1);
    ticks(5);
    read_disp(v);
    chk("t6_frozen", v, 10);
    ev(0, 0, 0, 0, 1);
    read_disp(v);
    chk("t6_live", v, 15);
`endif

    // randomized events against the model
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        ev(0, 0, 0, 0, 1);
      end else begin
        ev(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 5) == 0),
           1'($urandom_range(0, 24) == 0), 1'($urandom_range(0, 1)), 0);
      end
      if (n % 25 == 24) begin
        read_disp(v);
        chk("rnd_disp", v, shown());
      end
    end
    read_disp(v);
    chk("rnd_final", v, shown());

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
